// File: rtl/sample_player.sv
// -----------------------------------------------------------------------------
// sample_player
//
// Playback engine for recorded audio. Walks the sample BRAM from address 0 up
// to the captured length. The BRAM has a one-cycle registered read, so the
// engine prefetches one sample ahead into a holding buffer. It emits exactly
// one sample per external sample_tick, and can optionally loop.
//
// Parameters
//   ADDR_W   BRAM address width (depth = 2**ADDR_W)
//   DATA_W   sample width
//   SILENCE  unsigned midscale value driven when playback is stopped
//
// Ports
//   Clk           in   sole clock, rising edge
//   Reset_n       in   asynchronous active-low reset
//   start         in   pulse: (re)start playback from address 0
//   stop          in   pulse: abort playback, output SILENCE
//   loop_en       in   wrap to address 0 after the last sample
//   rec_len       in   number of recorded samples, captured on start
//   sample_tick   in   sample-rate strobe
//   ram_addr      out  BRAM read address
//   ram_rd        out  read request; ram_addr is valid while high
//   ram_data      in   BRAM registered read data
//   sample_out    out  current output sample (registered)
//   sample_valid  out  pulse when sample_out updates from playback
//   playing       out  high whenever not idle
//   done          out  pulse with the final sample of non-looping playback
//   underrun      out  pulse when a tick arrives before the prefetch is ready
// -----------------------------------------------------------------------------
module sample_player #(
    parameter int                 ADDR_W  = 18,
    parameter int                 DATA_W  = 10,
    parameter logic [DATA_W-1:0]  SILENCE = 10'd512
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   rec_len,
    input  logic              sample_tick,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              playing,
    output logic              done,
    output logic              underrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_READY = 2'd3;

    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_len;
    logic [DATA_W-1:0] r_buf;
    logic              r_pend;
    logic [DATA_W-1:0] r_sample_out;
    logic              r_sample_valid;
    logic              r_done;
    logic              r_underrun;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [ADDR_W:0]   w_len_nxt;
    logic [ADDR_W:0]   w_len_clamp;
    logic              w_start_ok;
    logic              w_override;
    logic              w_fetching;
    logic              w_service;
    logic              w_fire;
    logic              w_last;
    logic              w_done_go;
    logic              w_underrun_go;

    // ---------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------
    assign w_len_clamp = (rec_len > DEPTH) ? DEPTH : rec_len;
    assign w_start_ok  = start && (rec_len != '0);

    // stop and an accepted start both pre-empt whatever the FSM would do
    assign w_override  = stop || w_start_ok;

    assign w_fetching  = (r_state == S_FETCH) || (r_state == S_LATCH);
    assign w_service   = (r_state == S_READY) && (sample_tick || r_pend);
    assign w_fire      = w_service && !w_override;

    // Compare in ADDR_W+1 bits so a full-depth length (2**ADDR_W) works
    assign w_last        = ({1'b0, r_ptr} == (r_len - LEN_ONE));
    assign w_done_go     = w_fire && w_last && !loop_en;
    assign w_underrun_go = !w_override && sample_tick && w_fetching;

    // ---------------------------------------------------------------------
    // Next-state logic for sequencing registers
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_len_nxt   = r_len;

        if (stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start_ok) begin
            w_state_nxt = S_FETCH;
            w_ptr_nxt   = '0;
            w_len_nxt   = w_len_clamp;
        end else begin
            case (r_state)
                S_FETCH: w_state_nxt = S_LATCH;
                S_LATCH: w_state_nxt = S_READY;
                S_READY: begin
                    if (w_service) begin
                        if (w_last) begin
                            if (loop_en) begin
                                w_ptr_nxt   = '0;
                                w_state_nxt = S_FETCH;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_ptr_nxt   = r_ptr + PTR_ONE;
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Prefetch buffer and deferred-tick flag
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_buf <= '0;
        end else if (!stop && w_start_ok) begin
            r_buf <= '0;
        end else if (!w_override && (r_state == S_LATCH)) begin
            r_buf <= ram_data;
        end
    end

    // A tick during FETCH/LATCH is remembered once; further ticks are
    // dropped (still flagged as underrun) so no address is ever skipped.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pend <= 1'b0;
        end else if (w_override) begin
            r_pend <= 1'b0;
        end else if (w_underrun_go) begin
            r_pend <= 1'b1;
        end else if (w_fire) begin
            r_pend <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sample_out   <= SILENCE;
            r_sample_valid <= 1'b0;
            r_done         <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_sample_valid <= w_fire;
            r_done         <= w_done_go;
            r_underrun     <= w_underrun_go;
            if (stop) begin
                r_sample_out <= SILENCE;
            end else if (w_fire) begin
                r_sample_out <= r_buf;
            end
        end
    end

    assign ram_addr     = r_ptr;
    assign ram_rd       = w_fetching;
    assign playing      = (r_state != S_IDLE);
    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign done         = r_done;
    assign underrun     = r_underrun;

endmodule
